// File: rtl/serial_rx_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_rx_ctrl_pkg                                           |
// | Description : Shared definitions for the serial bus receive controller:   |
// |               FSM state encoding, watchdog width, default frame lengths.  |
// |               The frame lengths are also used by the transmit controller. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package serial_rx_ctrl_pkg;

  // Watchdog counter width (covers bit length plus slack with headroom).
  localparam int WD_WIDTH = 6;

  // Default converter port and length-field widths.
  localparam int DEF_PORT_WIDTH = 14;
  localparam int DEF_LEN_WIDTH  = 4;

  // Default frame layout: address phase then data phase, LSB first.
  localparam logic [3:0] DEF_ADDR_BITS = 4'd4;
  localparam logic [3:0] DEF_DATA_BITS = 4'd8;

  // Receive controller states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_STOP = 3'd3,
    ST_ERR  = 3'd4
  } rx_state_e;

  // Mask with the low n bits set; saturates to all ones for n >= 32.
  function automatic logic [31:0] low_mask(input int n);
    if (n >= 32) begin
      return '1;
    end
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_rx_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_rx_ctrl_if                                            |
// | Description : Bundles the converter control/return path and the client    |
// |               valid/ready delivery path of the receive controller.        |
// |               master = the controller, slave = converter plus client.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface serial_rx_ctrl_if
  import serial_rx_ctrl_pkg::*;
#(
  parameter int PORT_WIDTH = DEF_PORT_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) ();

  // Converter side
  logic                  sp_en;
  logic [LEN_WIDTH-1:0]  sp_bit_length;
  logic [PORT_WIDTH-1:0] sp_dout;
  logic                  sp_dv;

  // Client side
  logic [PORT_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  modport master (
    output sp_en,
    output sp_bit_length,
    input  sp_dout,
    input  sp_dv,
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  sp_en,
    input  sp_bit_length,
    output sp_dout,
    output sp_dv,
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );

endinterface
`default_nettype wire

// File: rtl/serial_rx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_rx_ctrl                                               |
// | Description : Receive-side frame controller. Detects a start bit, runs    |
// |               the serial_parallel converter through an address phase and  |
// |               a data phase, filters on slave address and delivers data    |
// |               words over a valid/ready handshake. Every output is a flop. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module serial_rx_ctrl
  import serial_rx_ctrl_pkg::*;
#(
  parameter int                   PORT_WIDTH = DEF_PORT_WIDTH,
  parameter int                   LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter logic [LEN_WIDTH-1:0] ADDR_BITS  = LEN_WIDTH'(DEF_ADDR_BITS),
  parameter logic [LEN_WIDTH-1:0] DATA_BITS  = LEN_WIDTH'(DEF_DATA_BITS),
  parameter logic [LEN_WIDTH-1:0] SLAVE_ADDR = LEN_WIDTH'(4'd5),
  parameter logic [WD_WIDTH-1:0]  TO_SLACK   = 6'd4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  serial_rx_ctrl_if.master bus,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  // Field masks: the address sits in the low ADDR_BITS of the converter word,
  // the data in the low DATA_BITS; everything above is forced to zero.
  localparam logic [PORT_WIDTH-1:0] ADDR_MASK  = PORT_WIDTH'(low_mask(int'(ADDR_BITS)));
  localparam logic [PORT_WIDTH-1:0] DATA_MASK  = PORT_WIDTH'(low_mask(int'(DATA_BITS)));
  localparam logic [PORT_WIDTH-1:0] SLAVE_WORD = PORT_WIDTH'(SLAVE_ADDR);

  // State and registered outputs
  rx_state_e             state_q,     state_d;
  logic                  hit_q,       hit_d;
  logic [WD_WIDTH-1:0]   wd_q,        wd_d;
  logic                  sp_en_q,     sp_en_d;
  logic [LEN_WIDTH-1:0]  bit_len_q,   bit_len_d;
  logic [PORT_WIDTH-1:0] rx_data_q,   rx_data_d;
  logic                  rx_valid_q,  rx_valid_d;
  logic                  busy_q,      busy_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q,   overrun_d;

  // Helper terms
  logic [WD_WIDTH-1:0]   wd_inc;
  logic [WD_WIDTH-1:0]   wd_limit;
  logic                  wd_expired;
  logic                  addr_match;
  logic                  buf_free;

  // The phase length currently driven to the converter is also the
  // watchdog reference: a phase may last its bit count plus the slack.
  assign wd_inc     = wd_q + 1'b1;
  assign wd_limit   = WD_WIDTH'(bit_len_q) + TO_SLACK;
  assign wd_expired = (wd_inc == wd_limit);
  assign addr_match = ((bus.sp_dout & ADDR_MASK) == SLAVE_WORD);

  // The holding register may take a new word if it is empty or is being
  // emptied by the client in this same cycle (accept-then-load).
  assign buf_free   = ~rx_valid_q | bus.rx_ready;

  // Frame sequencing, watchdog, receive buffer update and event pulses.
  always_comb begin
    state_d     = state_q;
    hit_d       = hit_q;
    wd_d        = wd_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~bus.rx_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A low bus line is the start bit; the converter is enabled from
        // the next cycle so the first address bit is captured right away.
        if (!din) begin
          state_d = ST_ADDR;
          wd_d    = '0;
        end
      end

      ST_ADDR: begin
        if (bus.sp_dv) begin
          hit_d   = addr_match;
          wd_d    = '0;
          state_d = ST_DATA;
        end else if (wd_expired) begin
          frame_err_d = 1'b1;
          state_d     = ST_ERR;
        end else begin
          wd_d = wd_inc;
        end
      end

      ST_DATA: begin
        // Frames for other slaves are clocked through to stay aligned with
        // the bus, but never touch the client-facing outputs.
        if (bus.sp_dv) begin
          if (hit_q) begin
            if (buf_free) begin
              rx_data_d  = bus.sp_dout & DATA_MASK;
              rx_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end
          state_d = ST_STOP;
        end else if (wd_expired) begin
          frame_err_d = 1'b1;
          state_d     = ST_ERR;
        end else begin
          wd_d = wd_inc;
        end
      end

      ST_STOP, ST_ERR: begin
        // Wait for the line to return to idle before looking for a start.
        if (din) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Converter controls and busy are decoded from the next state so they
  // change on the same edge as the state register.
  always_comb begin
    sp_en_d   = 1'b0;
    bit_len_d = ADDR_BITS;
    busy_d    = (state_d != ST_IDLE);
    if (state_d == ST_ADDR) begin
      sp_en_d = 1'b1;
    end
    if (state_d == ST_DATA) begin
      sp_en_d   = 1'b1;
      bit_len_d = DATA_BITS;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hit_q       <= 1'b0;
      wd_q        <= '0;
      sp_en_q     <= 1'b0;
      bit_len_q   <= ADDR_BITS;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hit_q       <= hit_d;
      wd_q        <= wd_d;
      sp_en_q     <= sp_en_d;
      bit_len_q   <= bit_len_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.sp_en         = sp_en_q;
  assign bus.sp_bit_length = bit_len_q;
  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign busy              = busy_q;
  assign frame_err         = frame_err_q;
  assign overrun           = overrun_q;

endmodule
`default_nettype wire
